// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and type encoding, receiver framing states.
package noc_pkg;

    localparam int FLIT_WIDTH_DEF = 34;
    localparam int TYPE_MSB       = 33;
    localparam int TYPE_LSB       = 32;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_TAIL     = 2'b01,
        FLIT_HEAD     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } rx_state_e;

    // True for the flit types that close a packet.
    function automatic logic is_tail(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small receive buffer with a combinational head output that reads as zero when empty.
module flit_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is refused even if a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count == DEPTH_C);
    assign empty_o = (count == '0);
    assign dout_o  = empty_o ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/async_flit_receiver.sv
// Receives 2-phase bundled-data flits from an upstream router, buffers them,
// and checks packet framing.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | between packets; expecting HEAD or HEADTAIL
//   ST_IN_PKT  | inside a packet; expecting BODY or TAIL
module async_flit_receiver
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_up_i,
    input  logic [FLIT_WIDTH-1:0] flit_up_i,
    output logic                  ack_up_o,
    output logic                  Tailpassed_up_o,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  proto_err_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   ack_q;
    logic                   capture;
    logic                   tail_q;
    logic                   err_q;
    logic                   err_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    flit_type_e             rx_type;
    rx_state_e              state_q;
    rx_state_e              state_d;

    assign req_sync = sync_q[SYNC_STAGES-1];
    // Bundled data is stable while the phases differ, so it can be sampled directly.
    assign capture  = (req_sync != ack_q) && !fifo_full;
    assign rx_type  = flit_type_e'(flit_up_i[TYPE_MSB:TYPE_LSB]);

    assign ack_up_o        = ack_q;
    assign Tailpassed_up_o = tail_q;
    assign proto_err_o     = err_q;
    assign valid_o         = !fifo_empty;

    // Request synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_up_i};
        end
    end

    // Acknowledge toggle, tail pulse, sticky error and framing state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            tail_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            if (capture) begin
                ack_q <= ~ack_q;
            end
            tail_q  <= capture && is_tail(rx_type);
            err_q   <= err_q | err_d;
            state_q <= state_d;
        end
    end

    // Framing next state; a violating flit is still accepted and resynchronizes the FSM.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (capture) begin
            case (state_q)
                ST_IDLE: begin
                    unique case (rx_type)
                        FLIT_HEAD:     state_d = ST_IN_PKT;
                        FLIT_HEADTAIL: state_d = ST_IDLE;
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_IN_PKT: begin
                    unique case (rx_type)
                        FLIT_BODY: state_d = ST_IN_PKT;
                        FLIT_TAIL: state_d = ST_IDLE;
                        FLIT_HEAD: begin
                            err_d   = 1'b1;
                            state_d = ST_IN_PKT;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    flit_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (capture),
        .din_i   (flit_up_i),
        .pop_i   (ready_i),
        .dout_o  (flit_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_async_flit_receiver.sv
// Scoreboard bench for async_flit_receiver: the sender pushes expected flits,
// a negedge monitor pops and compares whatever the DUT hands out.
module tb_async_flit_receiver;
    import noc_pkg::*;

    localparam int FW    = 34;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam logic [FW-1:0] HT_A5 = 34'h3_A5A5A5A5;

    logic          clk;
    logic          rst;
    logic          req;
    logic          ready;
    logic [FW-1:0] flit_in;
    logic          ack;
    logic          tail;
    logic [FW-1:0] flit_out;
    logic          valid;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] mon_e;
    bit            m_in_pkt;
    bit            m_err;
    int            m_tails;
    int            seen_tails;
    logic          prev_tail;

    async_flit_receiver #(
        .FLIT_WIDTH  (FW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_up_i        (req),
        .flit_up_i       (flit_in),
        .ack_up_o        (ack),
        .Tailpassed_up_o (tail),
        .flit_o          (flit_out),
        .valid_o         (valid),
        .ready_i         (ready),
        .proto_err_o     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference model: packet framing from the type rules, not from any state encoding.
    task automatic model_flit(input logic [1:0] t, input logic [31:0] p);
        bit starts;
        exp_q.push_back({t, p});
        starts = (t == 2'b10) || (t == 2'b11);
        if (starts) begin
            if (m_in_pkt) m_err = 1'b1;
            m_in_pkt = (t == 2'b10);
        end else begin
            if (!m_in_pkt) m_err = 1'b1;
            m_in_pkt = m_in_pkt && (t == 2'b00);
        end
        if (t == 2'b01 || t == 2'b11) m_tails++;
    endtask

    task automatic issue(input logic [1:0] t, input logic [31:0] p);
        flit_in = {t, p};
        req     = ~req;
        model_flit(t, p);
    endtask

    task automatic wait_ack(input int budget, input string name, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (ack === req) begin
                ok = 1'b1;
                break;
            end
            if (rnd) ready = 1'($urandom_range(0, 1));
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] p, input int budget,
                        input string name, input bit rnd);
        issue(t, p);
        wait_ack(budget, name, rnd);
    endtask

    task automatic chk_state(input string name);
        chk(name, 64'(dut.state_q == ST_IN_PKT), 64'(m_in_pkt));
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_drained"}, 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_valid_idle"}, 64'(valid), 64'd0);
        chk({name, "_tails"}, 64'(seen_tails), 64'(m_tails));
        chk({name, "_proto_err"}, 64'(err), 64'(m_err));
        chk_state({name, "_state"});
    endtask

    // Monitor: pops the scoreboard on each accepted flit and watches the tail pulse.
    initial begin
        prev_tail  = 1'b0;
        seen_tails = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_tail = 1'b0;
            end else begin
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_flit: got %h expected none", flit_out);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("flit_out", 64'(flit_out), 64'(mon_e));
                    end
                end
                if (tail) begin
                    seen_tails++;
                    chk("tail_one_cycle", 64'(prev_tail), 64'd0);
                end
                prev_tail = tail;
            end
        end
    end

    initial begin
        int len;
        logic [1:0] t;

        rst      = 1'b1;
        req      = 1'b0;
        ready    = 1'b0;
        flit_in  = '0;
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        m_tails  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_flit", 64'(flit_out), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_tail", 64'(tail), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single HEADTAIL flit
        issue(2'b11, 32'hA5A5A5A5);
        wait_ack(SS + 1, "ht_ack_latency", 1'b0);
        chk("ht_valid", 64'(valid), 64'd1);
        chk("ht_flit", 64'(flit_out), 64'(HT_A5));
        chk("ht_tail_pulse", 64'(tail), 64'd1);
        drain("single");

        // Four-flit packet with the consumer always ready
        ready = 1'b1;
        send(2'b10, $urandom, 10, "pkt_head_ack", 1'b0);
        send(2'b00, $urandom, 10, "pkt_body_ack", 1'b0);
        send(2'b00, $urandom, 10, "pkt_body_ack", 1'b0);
        send(2'b01, $urandom, 10, "pkt_tail_ack", 1'b0);
        drain("pkt4");

        // Backpressure: four fill the buffer, the fifth stalls, then full+pop
        ready = 1'b0;
        send(2'b10, $urandom, 10, "bp_ack", 1'b0);
        send(2'b00, $urandom, 10, "bp_ack", 1'b0);
        send(2'b00, $urandom, 10, "bp_ack", 1'b0);
        send(2'b00, $urandom, 10, "bp_ack", 1'b0);
        issue(2'b01, $urandom);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_fifth_held", 64'(ack === req), 64'd0);
        chk("bp_full_count", 64'(dut.u_fifo.count), 64'd4);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("fullpop_count_after_pop", 64'(dut.u_fifo.count), 64'd3);
        chk("fullpop_no_ack_yet", 64'(ack === req), 64'd0);
        @(posedge clk); #1;
        chk("fullpop_count_refill", 64'(dut.u_fifo.count), 64'd4);
        chk("fullpop_fifth_ack", 64'(ack === req), 64'd1);
        drain("backpressure");

        // Framing error: BODY in IDLE, then a normal packet
        ready = 1'b1;
        send(2'b00, $urandom, 10, "ferr_body_ack", 1'b0);
        drain("ferr");
        send(2'b10, $urandom, 10, "ferr_head_ack", 1'b0);
        chk_state("ferr_head_in_pkt");
        send(2'b01, $urandom, 10, "ferr_tail_ack", 1'b0);
        drain("ferr_recover");

        // Reset mid-packet with flits still buffered
        ready = 1'b0;
        send(2'b10, $urandom, 10, "mid_head_ack", 1'b0);
        send(2'b00, $urandom, 10, "mid_body_ack", 1'b0);
        send(2'b00, $urandom, 10, "mid_body_ack", 1'b0);
        chk("mid_valid_before", 64'(valid), 64'd1);
        #2;
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("async_rst_ack", 64'(ack), 64'd0);
        chk("async_rst_valid", 64'(valid), 64'd0);
        chk("async_rst_flit", 64'(flit_out), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        chk("async_rst_tail", 64'(tail), 64'd0);
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        @(posedge clk); #1;
        ready = 1'b1;
        send(2'b11, $urandom, 10, "post_rst_ht_ack", 1'b0);
        drain("post_rst");

        // Random legal packets with random consumer stalls
        for (int k = 0; k < 15; k++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                if (len == 1)          t = 2'b11;
                else if (j == 0)       t = 2'b10;
                else if (j == len - 1) t = 2'b01;
                else                   t = 2'b00;
                send(t, $urandom, 200, "rnd_ack", 1'b1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        drain("rnd_legal");

        // Random types including framing violations
        for (int k = 0; k < 30; k++) begin
            send(2'($urandom_range(0, 3)), $urandom, 200, "rnd_any_ack", 1'b1);
        end
        drain("rnd_any");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/async_flit_receiver.md
ASYNC_FLIT_RECEIVER -- requirements
Module: async_flit_receiver

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 34: flit width in bits; [33:32] type, [31:0] payload.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries, a power of two, at least 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on req_up_i, at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_up_i, input, 1 bit: 2-phase request from the upstream router output port; each toggle marks one flit.
REQ-007 SHALL have port flit_up_i, input, FLIT_WIDTH bits: bundled data, stable from a req_up_i toggle until the matching ack_up_o toggle.
REQ-008 SHALL have port ack_up_o, output, 1 bit: 2-phase acknowledge back to the upstream router.
REQ-009 SHALL have port Tailpassed_up_o, output, 1 bit: one-cycle pulse when a TAIL or HEADTAIL flit is acknowledged.
REQ-010 SHALL have port flit_o, output, FLIT_WIDTH bits: head-of-buffer flit.
REQ-011 SHALL have port valid_o, output, 1 bit: flit_o is valid.
REQ-012 SHALL have port ready_i, input, 1 bit: the consumer accepts flit_o when valid_o and ready_i are both high.
REQ-013 SHALL have port proto_err_o, output, 1 bit: sticky flag for a packet-framing violation.

Function
REQ-014 SHALL encode flit type as HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
REQ-015 SHALL pass req_up_i through SYNC_STAGES flops to give req_sync.
REQ-016 SHALL treat a flit as pending when req_sync differs from ack_up_o.
REQ-017 SHALL capture flit_up_i into the buffer in the first cycle where a flit is pending and the buffer is not full; ack_up_o toggles on the same clock edge.
REQ-018 SHALL leave ack_up_o unchanged while the buffer is full, so the upstream stalls with the pending flit held.
REQ-019 SHALL capture at most one flit per pending phase; req_sync equals ack_up_o again after the capture edge.
REQ-020 SHALL make flit_o and valid_o combinational from the buffer head; flit_o is zero when the buffer is empty.
REQ-021 SHALL give a minimum latency of one cycle from the capture edge to valid_o high.
REQ-022 SHALL, when a capture and a pop occur in the same cycle with the buffer full, perform the pop only; the capture happens the next cycle.
REQ-023 SHALL allow a simultaneous capture and pop at any other occupancy, with occupancy unchanged.
REQ-024 SHALL use ceil(log2(FIFO_DEPTH))-bit read/write pointers that wrap modulo FIFO_DEPTH, plus a (ceil(log2(FIFO_DEPTH))+1)-bit count.
REQ-025 SHALL implement the framing FSM as follows:
  - states IDLE and IN_PKT, advanced only on captured flits;
  - IDLE + HEAD -> IN_PKT;
  - IDLE + HEADTAIL -> IDLE;
  - IN_PKT + BODY -> IN_PKT;
  - IN_PKT + TAIL -> IDLE.
REQ-026 SHALL set proto_err_o on BODY or TAIL in IDLE, and on HEAD or HEADTAIL in IN_PKT.
REQ-027 SHALL, on such an error, still buffer and acknowledge the flit; next state = IN_PKT if the flit is HEAD, otherwise IDLE.
REQ-028 SHALL assert Tailpassed_up_o in the cycle after a TAIL or HEADTAIL capture edge, for exactly one cycle.

Reset
REQ-029 SHALL, while rst_i is high, hold all of the following at zero: ack_up_o, synchronizer flops, pointers, count, Tailpassed_up_o, proto_err_o, valid_o.
REQ-030 SHALL hold the FSM in IDLE while rst_i is high.
REQ-031 SHALL, on reset mid-packet, discard buffered flits; upstream req and ack phases must be re-aligned externally, as the router resets alongside.

Structure
REQ-032 SHALL place the flit type enum, the type field position, and the FLIT_WIDTH default in the shared package noc_pkg.
REQ-033 SHALL instantiate the buffer as the sub-module flit_fifo: parameterized width and depth, push/pop/full/empty.
REQ-034 SHALL keep the synchronizer, ack toggle, and FSM in async_flit_receiver.

Verification
REQ-035 SHALL cover single flit: HEADTAIL payload 0xA5A5A5A5, req toggle 0->1.
  - ack_up_o goes to 1 within SYNC_STAGES+1 cycles.
  - flit_o = 34'h3_A5A5A5A5 with valid_o high.
  - Tailpassed_up_o pulses once.
REQ-036 SHALL cover a 4-flit packet HEAD, BODY, BODY, TAIL with ready_i=1.
  - four ack toggles; outputs in order.
  - proto_err_o stays 0; FSM ends in IDLE.
REQ-037 SHALL cover backpressure: ready_i=0 and 5 flits sent.
  - 4 acks; the 5th req is held unacknowledged.
  - setting ready_i=1 for one cycle lets the 5th ack follow.
REQ-038 SHALL cover framing error: BODY sent in IDLE.
  - proto_err_o=1, flit still delivered.
  - a following HEAD is accepted as a normal HEAD.
REQ-039 SHALL cover full plus simultaneous pop: buffer full, pending flit, ready_i=1.
  - count drops to 3, then returns to 4 the next cycle.
  - no flit lost.
REQ-040 SHALL cover reset mid-packet: rst_i asserted after HEAD and BODY.
  - all outputs go to 0 asynchronously.
  - valid_o=0; a new HEADTAIL after release is received without error.
